// File: rtl/pwm_generator.sv
// pwm_generator: per-channel double-buffered PWM stage; settings move from shadow to active
// only at each channel's own cycle boundary (wrap or SYNC), so pulses are never truncated.
module pwm_generator #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        SYNC,
    input  logic                        UPDATE,
    input  logic [DEPTH-1:0][WIDTH-1:0] CYCLE,
    input  logic [DEPTH-1:0]            OVER,
    input  logic [DEPTH-1:0][WIDTH-1:0] LEFT,
    input  logic [DEPTH-1:0][WIDTH-1:0] RIGHT,
    output logic [DEPTH-1:0]            PWM_OUT,
    output logic                        PENDING
);
    logic [DEPTH-1:0] pend;
    for (genvar i = 0; i < DEPTH; i++) begin : g_ch
        logic [WIDTH-1:0] s_cycle, s_left, s_right;
        logic [WIDTH-1:0] a_cycle, a_left, a_right;
        logic [WIDTH-1:0] t;
        logic             s_over, a_over, pend_r, pwm;
        logic             wrap, boundary, hit_left, hit_right;
        // >= rather than == keeps the counter bounded when the period shrinks
        always_comb begin
            wrap      = (a_cycle <= WIDTH'(1)) || (t >= a_cycle - WIDTH'(1));
            boundary  = SYNC || wrap;
            hit_left  = t >= a_left;
            hit_right = t < a_right;
        end
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                s_cycle <= '0;
                s_left  <= '0;
                s_right <= '0;
                s_over  <= 1'b0;
                a_cycle <= '0;
                a_left  <= '0;
                a_right <= '0;
                a_over  <= 1'b0;
                t       <= '0;
                pend_r  <= 1'b0;
                pwm     <= 1'b0;
            end else begin
                t      <= boundary ? '0 : t + WIDTH'(1);
                pwm    <= a_over ? (hit_left || hit_right) : (hit_left && hit_right);
                pend_r <= UPDATE || (pend_r && !boundary);
                if (boundary && pend_r) begin
                    a_cycle <= s_cycle;
                    a_left  <= s_left;
                    a_right <= s_right;
                    a_over  <= s_over;
                end
                if (UPDATE) begin
                    s_cycle <= CYCLE[i];
                    s_left  <= LEFT[i];
                    s_right <= RIGHT[i];
                    s_over  <= OVER[i];
                end
            end
        end
        assign PWM_OUT[i] = pwm;
        assign pend[i]    = pend_r;
    end
    assign PENDING = |pend;
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: random and directed stimulus against a cycle-level integer model of
// the double-buffered PWM rules, plus literal pulse-width, latency and PENDING timing checks.
module tb_pwm_generator;
    localparam int W = 13;
    localparam int D = 4;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                SYNC = 1'b0;
    logic                UPDATE = 1'b0;
    logic [D-1:0][W-1:0] cyc = '0;
    logic [D-1:0][W-1:0] lft = '0;
    logic [D-1:0][W-1:0] rgt = '0;
    logic [D-1:0]        ovr = '0;
    logic [D-1:0]        pwm;
    logic                pending;
    int                  n_cmp = 0;
    int                  n_bad = 0;
    bit                  run = 0;

    pwm_generator #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK), .RST(RST), .SYNC(SYNC), .UPDATE(UPDATE),
        .CYCLE(cyc), .OVER(ovr), .LEFT(lft), .RIGHT(rgt),
        .PWM_OUT(pwm), .PENDING(pending)
    );

    always #5 CLK = ~CLK;

    // model state: shadow, active, position within period, pending flag, expected output
    int s_c[D], s_l[D], s_r[D], s_o[D];
    int a_c[D], a_l[D], a_r[D], a_o[D];
    int pos[D], pnd[D], e_pwm[D];
    bit bnd;

    // wrapped pulse is low exactly on [right, left)
    function automatic int lit(int p, int l, int r, int o);
        return o ? int'(!(p >= r && p < l)) : int'(p >= l && p < r);
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < D; i++) begin
                s_c[i] = 0; s_l[i] = 0; s_r[i] = 0; s_o[i] = 0;
                a_c[i] = 0; a_l[i] = 0; a_r[i] = 0; a_o[i] = 0;
                pos[i] = 0; pnd[i] = 0; e_pwm[i] = 0;
            end
        end else begin
            for (int i = 0; i < D; i++) begin
                bnd = SYNC || a_c[i] <= 1 || pos[i] >= a_c[i] - 1;
                e_pwm[i] = lit(pos[i], a_l[i], a_r[i], a_o[i]);
                if (bnd && pnd[i] != 0) begin
                    a_c[i] = s_c[i]; a_l[i] = s_l[i]; a_r[i] = s_r[i]; a_o[i] = s_o[i];
                    pnd[i] = 0;
                end
                pos[i] = bnd ? 0 : pos[i] + 1;
                if (UPDATE) begin
                    s_c[i] = int'(cyc[i]); s_l[i] = int'(lft[i]);
                    s_r[i] = int'(rgt[i]); s_o[i] = int'(ovr[i]);
                    pnd[i] = 1;
                end
            end
        end
    end

    task automatic chk(string nm, int got, int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    int ep;
    always @(negedge CLK) begin
        if (run) begin
            ep = 0;
            for (int i = 0; i < D; i++) begin
                chk($sformatf("model_pwm%0d", i), int'(pwm[i]), e_pwm[i]);
                if (pnd[i] != 0) ep = 1;
            end
            chk("model_pending", int'(pending), ep);
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_upd;
        UPDATE = 1'b1;
        @(negedge CLK);
        UPDATE = 1'b0;
    endtask

    task automatic pulse_sync;
        SYNC = 1'b1;
        @(negedge CLK);
        SYNC = 1'b0;
    endtask

    task automatic load(int c, int l, int r, int o);
        for (int i = 0; i < D; i++) begin
            cyc[i] = W'(c); lft[i] = W'(l); rgt[i] = W'(r); ovr[i] = o[0];
        end
    endtask

    task automatic wait_pend_low(int lim, output int n);
        n = 0;
        while (pending && n < lim) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic count_high(int len, output int hi);
        hi = 0;
        for (int j = 0; j < len; j++) begin
            hi += int'(pwm[0]);
            @(negedge CLK);
        end
    endtask

    int n, hi;
    initial begin
        tick(2);
        RST = 1'b0;
        run = 1;
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_pending", int'(pending), 0);

        // basic pulse
        load(4096, 1000, 3000, 0);
        pulse_upd;
        chk("basic_pending_set", int'(pending), 1);
        pulse_sync;
        n = 0;
        while (!pwm[0] && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        chk("basic_first_rise", n, 1001);
        count_high(4096, hi);
        chk("basic_high_clocks", hi, 2000);

        // wrapped pulse
        load(4096, 3500, 500, 1);
        pulse_upd;
        wait_pend_low(5000, n);
        tick(1);
        count_high(4096, hi);
        chk("wrap_high_clocks", hi, 1096);

        // zero duty, then update at t = 100
        load(4096, 2048, 2048, 0);
        pulse_upd;
        pulse_sync;
        tick(99);
        load(4096, 0, 2048, 0);
        pulse_upd;
        chk("zero_pending_held", int'(pending), 1);
        hi = 0;
        n = 0;
        while (pending && n < 5000) begin
            hi += int'(pwm[0]);
            @(negedge CLK);
            n++;
        end
        chk("zero_high_clocks", hi, 0);
        chk("zero_pend_fall", n, 3996);
        tick(1);
        chk("zero_new_rise", int'(pwm[0]), 1);

        // mixed cycles
        load(4096, 0, 100, 0);
        cyc[0] = W'(2000);
        pulse_upd;
        pulse_sync;
        tick(500);
        for (int i = 0; i < D; i++) lft[i] = W'(50);
        pulse_upd;
        tick(1600);
        chk("mixed_pending_after_ch0", int'(pending), 1);
        wait_pend_low(5000, n);
        chk("mixed_pend_fall", n, 1995);

        // update coincident with a wrap
        load(16, 2, 6, 0);
        pulse_upd;
        pulse_sync;
        load(16, 4, 10, 0);
        pulse_upd;
        tick(14);
        load(16, 8, 12, 0);
        pulse_upd;
        chk("coinc_pending_kept", int'(pending), 1);
        wait_pend_low(100, n);
        chk("coinc_pend_fall", n, 16);

        // randomized settings and timing
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < D; i++) begin
                automatic int c = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 300);
                cyc[i] = W'(c);
                lft[i] = (c <= 1) ? '0 : W'($urandom_range(0, c - 1));
                rgt[i] = (c <= 1) ? '0 : W'($urandom_range(0, c - 1));
                ovr[i] = 1'($urandom_range(0, 1));
            end
            pulse_upd;
            tick($urandom_range(1, 400));
            if ($urandom_range(0, 3) == 0) pulse_sync;
        end

        // asynchronous reset while the output is high
        load(4096, 0, 3000, 0);
        pulse_upd;
        pulse_sync;
        load(4096, 100, 200, 0);
        pulse_upd;
        n = 0;
        while (!pwm[0] && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("prereset_pwm_high", int'(pwm[0]), 1);
        #2 RST = 1'b1;
        #1;
        chk("async_reset_pwm", int'(pwm), 0);
        chk("async_reset_pending", int'(pending), 0);
        @(negedge CLK);
        tick(3);
        RST = 1'b0;
        tick(50);
        chk("postreset_pwm_low", int'(pwm), 0);
        chk("postreset_pending_low", int'(pending), 0);
        load(10, 0, 5, 0);
        pulse_upd;
        tick(2);
        chk("postreset_reload_rise", int'(pwm[0]), 1);
        tick(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pwm_generator.md
# pwm_generator

Per-transducer PWM output stage directly downstream of the PWM preconditioner. It double-buffers each channel's LEFT/RIGHT/OVER edge values and CYCLE. It runs one free-running time counter per channel modulo that channel's cycle and drives one registered PWM bit per transducer. New settings take effect only at each channel's own cycle boundary, so a pulse is never truncated mid-period.

## Interface
Parameters:
- WIDTH, 13, bit width of cycle/edge values and of each time counter
- DEPTH, 249, number of transducer channels

Ports:
- CLK  in  1  system clock; all logic on posedge
- RST  in  1  reset; asynchronous, active-high
- SYNC  in  1  single-cycle pulse; forces every channel counter to 0 and applies pending settings
- UPDATE  in  1  single-cycle pulse; preconditioner outputs are valid, capture into shadow registers
- CYCLE  in  [WIDTH-1:0] x DEPTH  period per channel, in clocks
- OVER  in  1 x DEPTH  wrap flag per channel from preconditioner
- LEFT  in  [WIDTH-1:0] x DEPTH  rising-edge time per channel
- RIGHT  in  [WIDTH-1:0] x DEPTH  falling-edge time per channel
- PWM_OUT  out  1 x DEPTH  registered PWM output per channel
- PENDING  out  1  high while any channel holds shadow settings not yet applied

## Operation
- Per channel i, the block keeps four register sets:
  - shadow registers: s_cycle, s_left, s_right, s_over, plus pend flag
  - active registers: a_cycle, a_left, a_right, a_over
  - counter: t[WIDTH-1:0]
  - output register: pwm
- Reset (async): every register above is 0, PWM_OUT = 0, PENDING = 0. Reset asserted mid-period clears immediately; outputs stay low until settings are loaded again.
- Capture: on UPDATE, every channel loads its shadow registers from CYCLE/LEFT/RIGHT/OVER and sets pend = 1, all in the same cycle.
- Wrap condition per channel: wrap = (t >= a_cycle - 1) or a_cycle <= 1.
  - a_cycle of 0 or 1 holds t at 0.
  - Using >= prevents a runaway counter when a_cycle shrinks.
- Counter priority: SYNC > wrap > increment.
  - SYNC: t <= 0.
  - wrap: t <= 0.
  - otherwise: t <= t + 1.
- Apply: on (SYNC or wrap) with pend = 1, the channel loads its active registers from the shadow registers and clears pend.
- UPDATE in the same cycle as an apply:
  - Active registers take the old shadow contents.
  - Shadow registers take the new inputs.
  - pend stays 1.
- Compare, registered with one cycle of latency:
  - a_over = 0: pwm <= (t >= a_left) and (t < a_right)
  - a_over = 1: pwm <= (t >= a_left) or (t < a_right)
  - a_left == a_right with a_over = 0 gives a constant 0 (zero duty).
- PENDING = OR of all pend flags, driven from registers (no combinational input path).
- All comparisons are unsigned WIDTH-bit. No saturation: the preconditioner guarantees edge values lie in [0, cycle-1].

## Timing
- UPDATE at edge k: shadow registers valid and PENDING = 1 from edge k.
- Settings become active at the first wrap or SYNC edge after k, evaluated per channel; channels with different cycles apply at different times.
- New settings affect PWM_OUT one cycle after they become active (compare register).
- SYNC at edge k: t = 0 at k, t = 1 at k+1. PWM_OUT for t = 0 appears at k+1.
- A channel's PWM_OUT is high for exactly (a_right - a_left) clocks per period when a_over = 0.
- It is high for exactly (a_cycle - a_left + a_right) clocks per period when a_over = 1.
- PENDING falls one edge after the last channel applies.
- There are no handshakes back to the preconditioner. The controller must not pulse UPDATE until the preconditioner has finished (DEPTH plus pipeline depth clocks after its START).

## Test plan
- Basic pulse, all channels:
  - Stimulus: CYCLE = 4096, LEFT = 1000, RIGHT = 3000, OVER = 0, UPDATE, then SYNC.
  - Response: PWM_OUT high for t in 1000..2999, i.e. 2000 clocks of every 4096, with the first rise 1001 clocks after SYNC.
- Wrapped pulse:
  - Stimulus: LEFT = 3500, RIGHT = 500, OVER = 1, CYCLE = 4096.
  - Response: high for t in 0..499 and 3500..4095, total 1096 clocks per period, contiguous across the wrap.
- Zero duty and mid-period update:
  - Stimulus: LEFT = RIGHT = 2048, OVER = 0. Then, at t = 100, UPDATE with LEFT = 0, RIGHT = 2048.
  - Response: output stays 0 for the rest of the period. PENDING stays high until the wrap; the new pulse starts at the next period; PENDING falls one clock after the wrap.
- Mixed cycles:
  - Stimulus: channel 0 CYCLE = 2000, channel 1 CYCLE = 4096, UPDATE mid-run.
  - Response: channel 0 applies at its next wrap and channel 1 at its own. PENDING stays high until channel 1 applies.
- UPDATE coincident with a wrap:
  - Response: the previous shadow values go active, the new values remain pending, and they apply one period later.
- Reset mid-operation:
  - Stimulus: assert RST while PWM_OUT = 1.
  - Response: PWM_OUT = 0 and PENDING = 0 asynchronously. After release, t holds at 0 and outputs stay 0 until an UPDATE plus a wrap or SYNC occurs.
